// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared constants and state type for the pipelined operand mux
package mux_pipe_pkg;
  localparam int MUX_PIPE_MAX_IN = 16;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/mux_n_sel.sv
// mux_n_sel: combinational NUM_IN-way word selector; out-of-range select yields zero with err set
module mux_n_sel import mux_pipe_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);
  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++)
      if (int'(sel) == k) begin
        word = data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
  end
endmodule

// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: registered N-input operand mux with 2-entry skid buffer; MUX_PIPE_BYPASS_EN adds an empty-stage bypass
module mux_pipe_skid import mux_pipe_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;
  state_t state, state_nxt;
  entry_t head, head_nxt, skid, skid_nxt, cur;
  logic [WIDTH-1:0] word;
  logic err, accept, emit, bypass;
  mux_n_sel #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
    .data (in_data),
    .sel  (in_sel),
    .word (word),
    .err  (err)
  );
  assign cur = {word, in_sel, err};
`ifdef MUX_PIPE_BYPASS_EN
  assign bypass = state == EMPTY && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif
  assign in_ready  = state != TWO;
  assign accept    = in_valid && in_ready;
  assign out_valid = state != EMPTY || bypass;
  assign emit      = out_valid && out_ready;
  assign {out_data, out_sel, out_err} = bypass ? cur : head;
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      EMPTY: if (accept && !bypass) begin
        state_nxt = ONE;
        head_nxt  = cur;
      end
      ONE: if (accept && emit) head_nxt = cur;
        else if (accept) begin
          state_nxt = TWO;
          skid_nxt  = cur;
        end else if (emit) state_nxt = EMPTY;
      TWO: if (emit) begin
        state_nxt = ONE;
        head_nxt  = skid;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
endmodule

// File: tb/tb_mux_pipe_skid.sv
// tb_mux_pipe_skid: queue-model scoreboard plus directed literal checks for mux_pipe_skid
module tb_mux_pipe_skid;
  localparam int W = 32, N = 3, SW = 2;
  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          e;
  } ent_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [N*W-1:0] in_data = '0;
  logic [SW-1:0] in_sel = '0;
  logic in_ready, out_valid, out_err;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_sel;
  int errors = 0, checks = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  mux_pipe_skid #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );
  function automatic ent_t pick(input logic [N*W-1:0] d, input logic [SW-1:0] s);
    ent_t r;
    r.e = int'(s) >= N;
    r.d = r.e ? '0 : W'(d >> (W * int'(s)));
    r.s = s;
    return r;
  endfunction
  function automatic bit byp_now();
`ifdef MUX_PIPE_BYPASS_EN
    return q.size() == 0 && in_valid && out_ready && !flush;
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [SW-1:0] s, input logic r, input logic f);
    in_valid = v; in_sel = s; out_ready = r; flush = f;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  always @(posedge clk or negedge rst_n) begin
    bit push, pop;
    ent_t n;
    if (!rst_n || flush) q.delete();
    else if (!byp_now()) begin
      n = pick(in_data, in_sel);
      push = in_valid && q.size() < 2;
      pop = out_ready && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(n);
    end
  end
  always @(negedge clk) if (rst_n) begin
    ent_t e;
    logic v;
    v = q.size() > 0 || byp_now();
    e = byp_now() ? pick(in_data, in_sel) : (q.size() > 0 ? q[0] : '0);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      chk("out_data", out_data, e.d);
      chk("out_sel", 32'(out_sel), 32'(e.s));
      chk("out_err", 32'(out_err), 32'(e.e));
    end
  end
  initial begin
    in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", 32'(out_sel), 0);
    chk("rst_err", 32'(out_err), 0);
    rst_n = 1;
    tick();
    chk("rst_ready", 32'(in_ready), 1);
`ifdef MUX_PIPE_BYPASS_EN
    drive(1, 2, 1, 0);
    #1;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_data", out_data, 32'hCCCC0002);
    tick();
    drive(0, 0, 1, 0);
    #1;
    chk("basic_done", 32'(out_valid), 0);
`else
    drive(1, 2, 1, 0);
    tick();
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_data", out_data, 32'hCCCC0002);
    chk("basic_sel", 32'(out_sel), 2);
    chk("basic_ready", 32'(in_ready), 1);
    drive(0, 0, 1, 0);
    tick();
    chk("basic_done", 32'(out_valid), 0);
`endif
    drive(1, 0, 0, 0);
    tick();
    chk("stall_ready1", 32'(in_ready), 1);
    chk("stall_data1", out_data, 32'hAAAA0000);
    drive(1, 1, 0, 0);
    tick();
    chk("stall_full", 32'(in_ready), 0);
    drive(1, 2, 0, 0);
    tick();
    chk("stall_hold", out_data, 32'hAAAA0000);
    chk("stall_hold_v", 32'(out_valid), 1);
    chk("stall_hold_r", 32'(in_ready), 0);
    drive(1, 2, 1, 0);
    tick();
    chk("drain_1", out_data, 32'hBBBB0001);
    tick();
    chk("drain_2", out_data, 32'hCCCC0002);
    chk("drain_2s", 32'(out_sel), 2);
    drive(0, 0, 1, 0);
    tick();
    chk("drain_empty", 32'(out_valid), 0);
    drive(1, 3, 0, 0);
    tick();
    chk("ill_data", out_data, 0);
    chk("ill_err", 32'(out_err), 1);
    chk("ill_sel", 32'(out_sel), 3);
    drive(0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    tick();
    chk("fl_full", 32'(in_ready), 0);
    drive(1, 2, 0, 1);
    tick();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    drive(0, 0, 1, 0);
    repeat (3) begin
      tick();
      chk("fl_stale", 32'(out_valid), 0);
    end
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1);
    tick();
    chk("fl_one", 32'(out_valid), 0);
    drive(1, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", out_data, 0);
    chk("arst_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1;
    tick();
    chk("arst_after", 32'(out_valid), 0);
`ifdef MUX_PIPE_BYPASS_EN
    drive(1, 1, 1, 0);
    #1;
    chk("byp_valid", 32'(out_valid), 1);
    chk("byp_data", out_data, 32'hBBBB0001);
    drive(0, 0, 1, 0);
    tick();
    drive(1, 1, 0, 0);
    #1;
    chk("byp_stall", 32'(out_valid), 0);
    tick();
    chk("byp_reg", out_data, 32'hBBBB0001);
    drive(0, 0, 1, 0);
    tick();
`endif
    for (int i = 0; i < 10000; i++) begin
      in_data = {$urandom, $urandom, $urandom};
      in_sel = 2'($urandom_range(0, 3));
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 3;
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_pipe_skid.md
Name: mux_pipe_skid

Overview:
- Parametrised N-input, WIDTH-bit operand select mux for the pipelined RV32 datapath.
- The selected word is carried through a registered stage with a 2-entry skid buffer and a valid/ready handshake.
- Lets forwarding/operand selection sit at a stage boundary and honour hazard-unit stalls (out_ready low) and flushes without losing or duplicating operands.
- Select value travels alongside the data for debug and hazard checking.

Parameters:
- WIDTH, 32, data width of each input and the output
- NUM_IN, 4, number of selectable inputs (2..16, need not be a power of 2)
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NUM_IN*WIDTH  packed inputs; input k at bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  index of input to capture
- in_valid  input  1  upstream offers a transfer
- in_ready  output  1  block can accept a transfer
- flush  input  1  synchronous pipeline flush from hazard unit
- out_data  output  WIDTH  selected word at stage head
- out_sel  output  SEL_W  select value captured with out_data
- out_err  output  1  captured select was out of range (in_sel >= NUM_IN)
- out_valid  output  1  stage head holds a valid word
- out_ready  input  1  downstream accepts; low = stall

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_err=0, skid entry invalid; in_ready=1 once rst_n deasserts.
- Transfer rules:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
- Select path:
  - mux_word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN.
  - Otherwise mux_word = 0 and err = 1, captured with the word.
- Latency: 1 cycle from acceptance to out_valid (non-bypass build).
- Storage:
  - Head register (drives out_*).
  - Skid register holding {data, sel, err}.
- State machine: EMPTY, ONE (head valid), TWO (head+skid valid).
  - EMPTY: accept -> ONE (load head).
  - ONE:
    - accept & !emit -> TWO (load skid)
    - accept & emit -> ONE (load head with new word)
    - !accept & emit -> EMPTY
    - else hold
  - TWO:
    - emit -> ONE (head <= skid)
    - no accept possible, since in_ready=0
- in_ready = (state != TWO). It is registered/derived from state only and has no combinational path from out_ready.
- Ordering: strict FIFO order; no word is dropped or duplicated under any in_valid/out_ready pattern.
- Stall: while out_ready=0, out_data/out_sel/out_err/out_valid are stable.
- Flush:
  - Next state EMPTY, regardless of other inputs that cycle.
  - A transfer accepted in the flush cycle is discarded.
  - out_valid=0 the following cycle. Data registers need not clear.
- Reset mid-operation: immediate return to reset values; buffered words lost.
- out_valid is never asserted for a word whose capture coincided with flush.

Optional Feature:
- MUX_PIPE_BYPASS_EN defined: when state==EMPTY, in_valid=1, out_ready=1 and flush=0:
  - The word passes combinationally to out_* with out_valid=1 in the same cycle.
  - It is consumed with no register load.
  - Latency is 0 in that case; all other cases as above.
- Not defined: out_* driven only from registers; latency always 1.

Decomposition:
- Shared package mux_pipe_pkg:
  - MUX_PIPE_MAX_IN = 16 constant.
  - State enum typedef {EMPTY, ONE, TWO}.
  - Entry struct typedef {data, sel, err} parametrised by width via localparam in instantiator.
- One sub-module: mux_n_sel, the combinational WIDTH/NUM_IN selector producing {word, err}, reusable by the forwarding unit.

Test Plan:
- Reset and basic transfer:
  - Stimulus: reset, then NUM_IN=4, in_data={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, in_sel=2, one-cycle valid, out_ready=1.
  - Response: out_data=0xCCCC0002, out_sel=2, out_valid one cycle later, in_ready stays 1.
- Stall with back-to-back inputs:
  - Stimulus: out_ready=0, inputs sel=0, 1, 2 on consecutive cycles.
  - Response: first two accepted, in_ready=0 on the third. Release out_ready: outputs 0xAAAA0000, 0xBBBB0001 in order, then third accepted and emitted.
- Illegal select:
  - Stimulus: NUM_IN=3, in_sel=3.
  - Response: out_data=0, out_err=1, out_sel=3.
- Flush with buffer full:
  - Stimulus: state TWO, flush=1 together with in_valid=1.
  - Response: next cycle out_valid=0, in_ready=1; no stale word emitted afterwards.
- Async reset mid-stream:
  - Stimulus: assert rst_n low between clock edges.
  - Response: out_valid=0 immediately, without waiting for a clock edge.
- Bypass build (MUX_PIPE_BYPASS_EN):
  - Stimulus: empty stage, in_sel=1, out_ready=1.
  - Response: out_data=0xBBBB0001, out_valid=1 same cycle.
  - Stimulus: same with out_ready=0.
  - Response: 1-cycle registered path.
- Random soak: random in_valid/out_ready/flush for 10k cycles; scoreboard checks order, no loss, no duplication.
